// File: rtl/os_scan_drain.sv
// Output-drain controller for the output-stationary systolic array: walks the accumulator
// scan chain bottom row first and presents each captured row on a valid/ready stream.
module os_scan_drain #(
    parameter int WIDTH_MAC   = 48,
    parameter int ROWS        = 4,
    parameter int COLS        = 4,
    parameter int DRAIN_WAIT  = 2,
    parameter int CLEAR_AFTER = 1,
    parameter int CW          = $clog2(ROWS) + 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [COLS*WIDTH_MAC-1:0] col_mac_in,
    input  logic                      o_ready,
    output logic                      cscan_en,
    output logic                      drain_active,
    output logic                      array_clear,
    output logic                      o_valid,
    output logic [COLS*WIDTH_MAC-1:0] o_data,
    output logic [CW-1:0]             o_row,
    output logic                      o_last,
    output logic                      done
);

    localparam int WW = $clog2(DRAIN_WAIT + 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_CAPTURE,
        S_HOLD,
        S_DONE
    } state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   row_cnt_reg, row_cnt_next;
    logic [WW-1:0]   wait_cnt_reg, wait_cnt_next;
    logic            o_valid_reg, o_valid_next;
    logic [CW-1:0]   o_row_reg, o_row_next;
    logic            o_last_reg, o_last_next;
    logic            capture;
    logic [WIDTH_MAC-1:0] col_data_reg [COLS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            row_cnt_reg  <= '0;
            wait_cnt_reg <= '0;
            o_valid_reg  <= 1'b0;
            o_row_reg    <= '0;
            o_last_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            row_cnt_reg  <= row_cnt_next;
            wait_cnt_reg <= wait_cnt_next;
            o_valid_reg  <= o_valid_next;
            o_row_reg    <= o_row_next;
            o_last_reg   <= o_last_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        row_cnt_next  = row_cnt_reg;
        wait_cnt_next = wait_cnt_reg;
        o_valid_next  = o_valid_reg;
        o_row_next    = o_row_reg;
        o_last_next   = o_last_reg;
        capture       = 1'b0;
        cscan_en      = 1'b0;
        done          = 1'b0;
        array_clear   = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    wait_cnt_next = WW'(DRAIN_WAIT);
                    row_cnt_next  = '0;
                    state_next    = (DRAIN_WAIT > 0) ? S_WAIT : S_CAPTURE;
                end
            end
            S_WAIT: begin
                wait_cnt_next = wait_cnt_reg - 1'b1;
                if (wait_cnt_reg <= WW'(1)) begin
                    state_next = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                capture      = 1'b1;
                o_valid_next = 1'b1;
                o_row_next   = CW'(ROWS - 1) - row_cnt_reg;
                o_last_next  = (row_cnt_reg == CW'(ROWS - 1));
                state_next   = S_HOLD;
            end
            S_HOLD: begin
                if (o_ready) begin
                    o_valid_next = 1'b0;
                    if (o_last_reg) begin
                        state_next = S_DONE;
                    end else begin
                        // The chain shifts on the edge that ends this cycle, so the next
                        // CAPTURE already sees the row above.
                        cscan_en     = 1'b1;
                        row_cnt_next = row_cnt_reg + 1'b1;
                        state_next   = S_CAPTURE;
                    end
                end
            end
            S_DONE: begin
                done        = 1'b1;
                array_clear = (CLEAR_AFTER != 0);
                state_next  = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < COLS; gi++) begin : g_col
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    col_data_reg[gi] <= '0;
                end else if (capture) begin
                    col_data_reg[gi] <= col_mac_in[gi*WIDTH_MAC +: WIDTH_MAC];
                end
            end
            assign o_data[gi*WIDTH_MAC +: WIDTH_MAC] = col_data_reg[gi];
        end
    endgenerate

    assign drain_active = (state_reg != S_IDLE);
    assign o_valid      = o_valid_reg;
    assign o_row        = o_row_reg;
    assign o_last       = o_last_reg;

endmodule

// File: tb/tb_os_scan_drain.sv
// Directed bench for os_scan_drain: three configurations, each fed by a small scan-chain model.
module tb_os_scan_drain;

    localparam int W  = 48;
    localparam int NC = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   nvec = 0;
    int   nerr = 0;

    // Configuration A: ROWS=4, DRAIN_WAIT=0, CLEAR_AFTER=1
    logic start_a, ready_a, cscan_a, active_a, clear_a, valid_a, last_a, done_a;
    logic [NC*W-1:0] mac_a, data_a;
    logic [2:0]      row_a;
    os_scan_drain #(.WIDTH_MAC(W), .ROWS(4), .COLS(NC), .DRAIN_WAIT(0), .CLEAR_AFTER(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .col_mac_in(mac_a), .o_ready(ready_a),
        .cscan_en(cscan_a), .drain_active(active_a), .array_clear(clear_a), .o_valid(valid_a),
        .o_data(data_a), .o_row(row_a), .o_last(last_a), .done(done_a)
    );

    // Configuration B: ROWS=2, DRAIN_WAIT=3, CLEAR_AFTER=0
    logic start_b, ready_b, cscan_b, active_b, clear_b, valid_b, last_b, done_b;
    logic [NC*W-1:0] mac_b, data_b;
    logic [1:0]      row_b;
    os_scan_drain #(.WIDTH_MAC(W), .ROWS(2), .COLS(NC), .DRAIN_WAIT(3), .CLEAR_AFTER(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .col_mac_in(mac_b), .o_ready(ready_b),
        .cscan_en(cscan_b), .drain_active(active_b), .array_clear(clear_b), .o_valid(valid_b),
        .o_data(data_b), .o_row(row_b), .o_last(last_b), .done(done_b)
    );

    // Configuration C: ROWS=1, DRAIN_WAIT=0, CLEAR_AFTER=1
    logic start_c, ready_c, cscan_c, active_c, clear_c, valid_c, last_c, done_c;
    logic [NC*W-1:0] mac_c, data_c;
    logic [0:0]      row_c;
    os_scan_drain #(.WIDTH_MAC(W), .ROWS(1), .COLS(NC), .DRAIN_WAIT(0), .CLEAR_AFTER(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .col_mac_in(mac_c), .o_ready(ready_c),
        .cscan_en(cscan_c), .drain_active(active_c), .array_clear(clear_c), .o_valid(valid_c),
        .o_data(data_c), .o_row(row_c), .o_last(last_c), .done(done_c)
    );

    // Scan-chain models: row 0 is the top, the last row feeds col_mac_in, zero enters at the top.
    logic [NC*W-1:0] chain_a [4];
    logic [NC*W-1:0] pre_a [4];
    logic [NC*W-1:0] chain_b [2];
    logic [NC*W-1:0] pre_b [2];
    logic [NC*W-1:0] chain_c [1];
    logic [NC*W-1:0] pre_c [1];
    logic load_a, load_b, load_c;

    always @(posedge clk) begin
        if (load_a) begin
            for (int r = 0; r < 4; r++) chain_a[r] <= pre_a[r];
        end else if (cscan_a) begin
            for (int r = 3; r > 0; r--) chain_a[r] <= chain_a[r-1];
            chain_a[0] <= '0;
        end
    end

    always @(posedge clk) begin
        if (load_b) begin
            for (int r = 0; r < 2; r++) chain_b[r] <= pre_b[r];
        end else if (cscan_b) begin
            chain_b[1] <= chain_b[0];
            chain_b[0] <= '0;
        end
    end

    always @(posedge clk) begin
        if (load_c) chain_c[0] <= pre_c[0];
        else if (cscan_c) chain_c[0] <= '0;
    end

    assign mac_a = chain_a[3];
    assign mac_b = chain_b[1];
    assign mac_c = chain_c[0];

    function automatic logic [NC*W-1:0] rv(input int c0, input int c1);
        return {W'(c1), W'(c0)};
    endfunction

    task automatic preload_a(input int base);
        @(negedge clk);
        for (int r = 0; r < 4; r++) pre_a[r] = rv(base + 10*(r+1), base + 10*(r+1) + 1);
        load_a = 1'b1;
        @(negedge clk);
        load_a = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start_a = 0; start_b = 0; start_c = 0;
        ready_a = 1; ready_b = 1; ready_c = 1;
        load_a = 0; load_b = 0; load_c = 0;
        repeat (3) @(negedge clk);
        #1;
        nvec++;
        if ({cscan_a, active_a, clear_a, valid_a, last_a, done_a, data_a, row_a} !== '0) begin
            nerr++;
            $display("FAIL reset_a got ctl=%b data=%h row=%0d want all zero",
                     {cscan_a, active_a, clear_a, valid_a, last_a, done_a}, data_a, row_a);
        end
        nvec++;
        if ({cscan_b, active_b, clear_b, valid_b, last_b, done_b, data_b, row_b} !== '0) begin
            nerr++;
            $display("FAIL reset_b got ctl=%b data=%h row=%0d want all zero",
                     {cscan_b, active_b, clear_b, valid_b, last_b, done_b}, data_b, row_b);
        end
        nvec++;
        if ({cscan_c, active_c, clear_c, valid_c, last_c, done_c, data_c, row_c} !== '0) begin
            nerr++;
            $display("FAIL reset_c got ctl=%b data=%h row=%0d want all zero",
                     {cscan_c, active_c, clear_c, valid_c, last_c, done_c}, data_c, row_c);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Beats at cycles 2,4,6,8; shifts at 2,4,6; done/clear at 9; active over 1..9.
    task automatic test_basic_drain(input int base);
        logic [15:0] m_valid, m_cscan, m_done, m_active;
        logic [4:0]  obs, want;
        int k;
        m_valid = 16'h0154; m_cscan = 16'h0054; m_done = 16'h0200; m_active = 16'h03FE;
        preload_a(base);
        k = 0;
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            start_a = (t == 0);
            ready_a = 1'b1;
            #1;
            obs  = {valid_a, cscan_a, done_a, clear_a, active_a};
            want = {m_valid[t], m_cscan[t], m_done[t], m_done[t], m_active[t]};
            nvec++;
            if (obs !== want) begin
                nerr++;
                $display("FAIL basic_ctl cyc=%0d got v/cs/dn/clr/act=%b want %b", t, obs, want);
            end
            if (m_valid[t]) begin
                nvec++;
                if ({data_a, row_a, last_a} !== {rv(base + 40 - 10*k, base + 41 - 10*k), 3'(3 - k), k == 3}) begin
                    nerr++;
                    $display("FAIL basic_beat%0d got data=%h row=%0d last=%b want data=%h row=%0d last=%b",
                             k, data_a, row_a, last_a, rv(base + 40 - 10*k, base + 41 - 10*k), 3 - k, k == 3);
                end
                k++;
            end
        end
    endtask

    // o_ready low in cycles 4..6: beat 1 held 4..7, shifts at 2,7,9, done at 12.
    task automatic test_backpressure();
        logic [15:0] m_valid, m_cscan, m_done, m_active;
        logic [4:0]  obs, want;
        int k;
        m_valid = 16'h0AF4; m_cscan = 16'h0284; m_done = 16'h1000; m_active = 16'h1FFE;
        preload_a(0);
        k = 0;
        for (int t = 0; t < 15; t++) begin
            @(negedge clk);
            start_a = (t == 0);
            ready_a = !(t >= 4 && t <= 6);
            #1;
            obs  = {valid_a, cscan_a, done_a, clear_a, active_a};
            want = {m_valid[t], m_cscan[t], m_done[t], m_done[t], m_active[t]};
            nvec++;
            if (obs !== want) begin
                nerr++;
                $display("FAIL bp_ctl cyc=%0d got v/cs/dn/clr/act=%b want %b", t, obs, want);
            end
            if (m_valid[t]) begin
                nvec++;
                if ({data_a, row_a, last_a} !== {rv(40 - 10*k, 41 - 10*k), 3'(3 - k), k == 3}) begin
                    nerr++;
                    $display("FAIL bp_beat%0d cyc=%0d got data=%h row=%0d last=%b want data=%h row=%0d last=%b",
                             k, t, data_a, row_a, last_a, rv(40 - 10*k, 41 - 10*k), 3 - k, k == 3);
                end
                if (ready_a) k++;
            end
        end
        ready_a = 1'b1;
    endtask

    // A second start at cycle 3 must neither restart nor add beats.
    task automatic test_ignored_start();
        logic [15:0] m_valid, m_cscan, m_done, m_active;
        logic [4:0]  obs, want;
        int k;
        m_valid = 16'h0154; m_cscan = 16'h0054; m_done = 16'h0200; m_active = 16'h03FE;
        preload_a(500);
        k = 0;
        for (int t = 0; t < 14; t++) begin
            @(negedge clk);
            start_a = (t == 0) || (t == 3);
            ready_a = 1'b1;
            #1;
            obs  = {valid_a, cscan_a, done_a, clear_a, active_a};
            want = {m_valid[t], m_cscan[t], m_done[t], m_done[t], m_active[t]};
            nvec++;
            if (obs !== want) begin
                nerr++;
                $display("FAIL ign_ctl cyc=%0d got v/cs/dn/clr/act=%b want %b", t, obs, want);
            end
            if (m_valid[t]) begin
                nvec++;
                if ({data_a, row_a} !== {rv(540 - 10*k, 541 - 10*k), 3'(3 - k)}) begin
                    nerr++;
                    $display("FAIL ign_beat%0d got data=%h row=%0d want data=%h row=%0d",
                             k, data_a, row_a, rv(540 - 10*k, 541 - 10*k), 3 - k);
                end
                k++;
            end
        end
    endtask

    // D=3, ROWS=2, no clear: beats at 5 and 7, shift at 5, done at 8, array_clear never.
    task automatic test_flush_wait();
        logic [15:0] m_valid, m_cscan, m_done, m_active;
        logic [4:0]  obs, want;
        int k;
        m_valid = 16'h00A0; m_cscan = 16'h0020; m_done = 16'h0100; m_active = 16'h01FE;
        @(negedge clk);
        pre_b[0] = rv(5, 6);
        pre_b[1] = rv(7, 8);
        load_b = 1'b1;
        @(negedge clk);
        load_b = 1'b0;
        k = 0;
        for (int t = 0; t < 11; t++) begin
            @(negedge clk);
            start_b = (t == 0);
            ready_b = 1'b1;
            #1;
            obs  = {valid_b, cscan_b, done_b, clear_b, active_b};
            want = {m_valid[t], m_cscan[t], m_done[t], 1'b0, m_active[t]};
            nvec++;
            if (obs !== want) begin
                nerr++;
                $display("FAIL flush_ctl cyc=%0d got v/cs/dn/clr/act=%b want %b", t, obs, want);
            end
            if (m_valid[t]) begin
                nvec++;
                if ({data_b, row_b, last_b} !== {rv(7 - 2*k, 8 - 2*k), 2'(1 - k), k == 1}) begin
                    nerr++;
                    $display("FAIL flush_beat%0d got data=%h row=%0d last=%b want data=%h row=%0d last=%b",
                             k, data_b, row_b, last_b, rv(7 - 2*k, 8 - 2*k), 1 - k, k == 1);
                end
                k++;
            end
        end
    endtask

    // ROWS=1: single last beat at cycle 2, no shift, done/clear at 3.
    task automatic test_single_row();
        logic [15:0] m_valid, m_done, m_active;
        logic [4:0]  obs, want;
        m_valid = 16'h0004; m_done = 16'h0008; m_active = 16'h000E;
        @(negedge clk);
        pre_c[0] = rv(99, 100);
        load_c = 1'b1;
        @(negedge clk);
        load_c = 1'b0;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            start_c = (t == 0);
            ready_c = 1'b1;
            #1;
            obs  = {valid_c, cscan_c, done_c, clear_c, active_c};
            want = {m_valid[t], 1'b0, m_done[t], m_done[t], m_active[t]};
            nvec++;
            if (obs !== want) begin
                nerr++;
                $display("FAIL single_ctl cyc=%0d got v/cs/dn/clr/act=%b want %b", t, obs, want);
            end
            if (m_valid[t]) begin
                nvec++;
                if ({data_c, row_c, last_c} !== {rv(99, 100), 1'b0, 1'b1}) begin
                    nerr++;
                    $display("FAIL single_beat got data=%h row=%0d last=%b want data=%h row=0 last=1",
                             data_c, row_c, last_c, rv(99, 100));
                end
            end
        end
    endtask

    // Reset at cycle 5 clears every output at once; a fresh drain then runs normally.
    task automatic test_reset_mid_drain();
        preload_a(0);
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            start_a = (t == 0);
            ready_a = 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        nvec++;
        if ({cscan_a, active_a, clear_a, valid_a, last_a, done_a, data_a, row_a} !== '0) begin
            nerr++;
            $display("FAIL midreset got ctl=%b data=%h row=%0d want all zero",
                     {cscan_a, active_a, clear_a, valid_a, last_a, done_a}, data_a, row_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        test_basic_drain(200);
    endtask

    initial begin
        test_reset();
        test_basic_drain(0);
        test_backpressure();
        test_ignored_start();
        test_flush_wait();
        test_single_row();
        test_reset_mid_drain();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
